// File: rtl/activation_pkg.sv
// Shared opcodes, wide arithmetic type and clamp helpers for the activation stream unit.
package activation_pkg;

    typedef logic [2:0]         act_t;
    typedef logic signed [63:0] wide_t;

    localparam act_t ACT_NONE    = 3'b000;
    localparam act_t ACT_RELU    = 3'b001;
    localparam act_t ACT_RELU6   = 3'b010;
    localparam act_t ACT_SIGMOID = 3'b011;
    localparam act_t ACT_TANH    = 3'b100;
    localparam act_t ACT_LEAKY   = 3'b101;
    localparam act_t ACT_SWISH   = 3'b110;
    localparam act_t ACT_GELU    = 3'b111;

    function automatic wide_t clamp(input wide_t v, input wide_t lo, input wide_t hi);
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end else begin
            return v;
        end
    endfunction

    // Hard-sigmoid style ramp: (v/4 + one/2) limited to [0, one]
    function automatic wide_t hs(input wide_t v, input wide_t one);
        return clamp((v >>> 2) + (one >>> 1), 64'sd0, one);
    endfunction

    function automatic wide_t sat(input wide_t v, input int dw);
        wide_t max_v;
        max_v = (64'sd1 <<< (dw - 1)) - 64'sd1;
        return clamp(v, -max_v - 64'sd1, max_v);
    endfunction

endpackage

// File: rtl/activation_stream_unit_if.sv
// Input/output beat streams of the activation unit; slave is the unit side.
interface activation_stream_unit_if
    import activation_pkg::*;
#(
    parameter int LANES      = 8,
    parameter int DATA_WIDTH = 16
);
    logic                          in_valid;
    logic                          in_ready;
    logic [LANES*DATA_WIDTH-1:0]   in_data;
    act_t                          in_act;
    logic                          out_valid;
    logic                          out_ready;
    logic [LANES*DATA_WIDTH-1:0]   out_data;
    logic [LANES-1:0]              out_sat;

    modport master (
        output in_valid, in_data, in_act, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_act, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/activation_lane.sv
// One lane's three-stage datapath: pre-value/gate, gated product, requantise and saturate.
module activation_lane
    import activation_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int LEAKY_SHIFT = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en1,
    input  logic                         en2,
    input  logic                         en3,
    input  logic signed [DATA_WIDTH-1:0] x,
    input  act_t                         act,
    input  logic signed [DATA_WIDTH-1:0] scale,
    output logic signed [DATA_WIDTH-1:0] y,
    output logic                         sat_flag
);
    localparam wide_t ONE_W   = 64'sd1 <<< FRAC_BITS;
    localparam wide_t MAX_W   = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;
    localparam wide_t SIX_RAW = 64'sd6 * ONE_W;
    localparam wide_t SIX_W   = (SIX_RAW > MAX_W) ? MAX_W : SIX_RAW;

    wide_t x_w_s, p_s, g_s, prod_s, r_s, y_s;
    logic signed [DATA_WIDTH-1:0] p_r, f_r, y_r;
    logic signed [DATA_WIDTH:0]   g_r;   // one extra bit so ONE always fits
    logic                         sat_r;

    // Stage-1 opcode decode into pre-value and gate
    always_comb begin
        x_w_s = wide_t'(x);
        p_s   = x_w_s;
        g_s   = ONE_W;
        case (act)
            ACT_NONE:    begin p_s = x_w_s;                                   g_s = ONE_W; end
            ACT_RELU:    begin p_s = clamp(x_w_s, 64'sd0, MAX_W);             g_s = ONE_W; end
            ACT_RELU6:   begin p_s = clamp(x_w_s, 64'sd0, SIX_W);             g_s = ONE_W; end
            ACT_SIGMOID: begin p_s = hs(x_w_s, ONE_W);                        g_s = ONE_W; end
            ACT_TANH:    begin p_s = clamp(x_w_s, -ONE_W, ONE_W);             g_s = ONE_W; end
            ACT_LEAKY:   begin p_s = x_w_s[63] ? (x_w_s >>> LEAKY_SHIFT) : x_w_s; g_s = ONE_W; end
            ACT_SWISH:   begin p_s = x_w_s; g_s = hs(x_w_s, ONE_W); end
            ACT_GELU:    begin p_s = x_w_s; g_s = clamp((x_w_s >>> 1) + (ONE_W >>> 1), 64'sd0, ONE_W); end
            default:     begin p_s = x_w_s;                                   g_s = ONE_W; end
        endcase
    end

    // Stage-2 gated product and stage-3 requantisation with saturation
    always_comb begin
        prod_s = wide_t'(p_r) * wide_t'(g_r);
        r_s    = (wide_t'(f_r) * wide_t'(scale)) >>> FRAC_BITS;
        y_s    = sat(r_s, DATA_WIDTH);
    end

    // Stage-1 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_r <= '0;
            g_r <= '0;
        end else if (en1) begin
            p_r <= DATA_WIDTH'(p_s);
            g_r <= (DATA_WIDTH+1)'(g_s);
        end
    end

    // Stage-2 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_r <= '0;
        end else if (en2) begin
            f_r <= DATA_WIDTH'(prod_s >>> FRAC_BITS);
        end
    end

    // Stage-3 register, drives the lane outputs directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_r   <= '0;
            sat_r <= 1'b0;
        end else if (en3) begin
            y_r   <= DATA_WIDTH'(y_s);
            sat_r <= (r_s != y_s);
        end
    end

    assign y        = y_r;
    assign sat_flag = sat_r;

endmodule

// File: rtl/activation_stream_unit.sv
// Multi-lane streaming activation engine: valid/ready pipeline control, lane array, saturation counter.
module activation_stream_unit
    import activation_pkg::*;
#(
    parameter int LANES       = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int LEAKY_SHIFT = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    activation_stream_unit_if.slave      bus,
    input  logic signed [DATA_WIDTH-1:0] out_scale,
    input  logic                         sat_clr,
    output logic [CNT_WIDTH-1:0]         sat_count
);
    logic v1_r, v2_r, v3_r;
    logic adv1_s, adv2_s, adv3_s;
    logic signed [DATA_WIDTH-1:0] lane_y_s [LANES];
    logic                         lane_sat_s [LANES];
    logic [LANES*DATA_WIDTH-1:0]  out_data_s;
    logic [LANES-1:0]             out_sat_s;

    // Each stage moves forward when its successor can take the beat
    always_comb begin
        adv3_s = !v3_r || bus.out_ready;
        adv2_s = !v2_r || adv3_s;
        adv1_s = !v1_r || adv2_s;
    end

    // Stage valid bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            v3_r <= 1'b0;
        end else begin
            if (adv1_s) v1_r <= bus.in_valid;
            if (adv2_s) v2_r <= v1_r;
            if (adv3_s) v3_r <= v2_r;
        end
    end

    // Data registers only load on real beats, so held outputs stay stable
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        activation_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .FRAC_BITS   (FRAC_BITS),
            .LEAKY_SHIFT (LEAKY_SHIFT)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en1      (adv1_s && bus.in_valid),
            .en2      (adv2_s && v1_r),
            .en3      (adv3_s && v2_r),
            .x        (bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .act      (bus.in_act),
            .scale    (out_scale),
            .y        (lane_y_s[i]),
            .sat_flag (lane_sat_s[i])
        );
    end

    // Lane result packing
    always_comb begin
        out_data_s = '0;
        out_sat_s  = '0;
        for (int i = 0; i < LANES; i++) begin
            out_data_s[i*DATA_WIDTH +: DATA_WIDTH] = lane_y_s[i];
            out_sat_s[i]                           = lane_sat_s[i];
        end
    end

    // Saturated-beat counter: clear wins, sticks at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (v3_r && bus.out_ready && (|out_sat_s) && !(&sat_count)) begin
            sat_count <= sat_count + CNT_WIDTH'(1'b1);
        end
    end

    assign bus.in_ready  = adv1_s;
    assign bus.out_valid = v3_r;
    assign bus.out_data  = out_data_s;
    assign bus.out_sat   = out_sat_s;

endmodule

// File: doc/activation_stream_unit.md
# activation_stream_unit

Multi-lane, fixed-point, streaming activation engine with valid/ready handshake, placed between the systolic array's accumulator drain and the result buffer. It applies one of eight activation functions per beat to `LANES` signed lanes and requantises by a programmable scale. The output is saturated to `DATA_WIDTH`, and saturation events are counted. It supersedes the single-value, enable-only activation stage with a generic-width, back-pressurable, three-stage pipeline.

## Interface
Parameters:
- `LANES`, 8: parallel lanes per beat; all lanes share one opcode.
- `DATA_WIDTH`, 16: signed two's-complement lane width.
- `FRAC_BITS`, 8: fractional bits of the Q format. ONE = 1<<FRAC_BITS.
- `LEAKY_SHIFT`, 3: leaky-ReLU slope is 2^-LEAKY_SHIFT.
- `CNT_WIDTH`, 16: width of the saturation counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: unit accepts the beat this cycle.
- `in_data` in LANES*DATA_WIDTH: lane i is at [i*DATA_WIDTH +: DATA_WIDTH].
- `in_act` in 3: opcode, carried with the beat.
- `out_scale` in DATA_WIDTH: signed Q-format requantisation multiplier. Quasi-static; it is sampled at stage 3.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts the output beat.
- `out_data` out LANES*DATA_WIDTH: results, using the same packing as `in_data`.
- `out_sat` out LANES: per-lane saturation flags for the current output beat.
- `sat_count` out CNT_WIDTH: count of output beats with any lane saturated.
- `sat_clr` in 1: synchronous clear of `sat_count`.

## Operation
Opcodes: 000 NONE, 001 RELU, 010 RELU6, 011 SIGMOID, 100 TANH, 101 LEAKY, 110 SWISH, 111 GELU.

Definitions used below:
- x is the lane input. MAX and MIN are the DATA_WIDTH signed limits. sat() clamps to [MIN, MAX].
- SIX = 6·ONE, clamped to MAX if it is not representable.
- hs(v) = clamp((v>>>2) + ONE/2, 0, ONE).
- All shifts are arithmetic and truncate (floor).

Stage 1 computes a pre-value p and a gate g per lane. The product p·g>>>FRAC_BITS gives f:
- NONE: p=x, g=ONE.
- RELU: p=max(x,0), g=ONE.
- RELU6: p=clamp(x,0,SIX), g=ONE.
- SIGMOID: p=hs(x), g=ONE.
- TANH: p=clamp(x,−ONE,ONE), g=ONE.
- LEAKY: p = x≥0 ? x : x>>>LEAKY_SHIFT, g=ONE.
- SWISH: p=x, g=hs(x).
- GELU: p=x, g=clamp((x>>>1)+ONE/2, 0, ONE).

Stage 2: f = (p·g)>>>FRAC_BITS, computed with a 2·DATA_WIDTH intermediate.

Stage 3:
- r = (f·out_scale)>>>FRAC_BITS at full width, then y = sat(r).
- `out_sat[i]` = 1 when r ≠ y.

Counter:
- `sat_count` increments by 1 per output handshake (out_valid & out_ready) with |out_sat ≠ 0.
- It saturates at all-ones and never wraps.
- `sat_clr` has priority over a same-cycle increment; the result is 0.

## Timing
- Pipeline registers are S1, S2 and S3, each with a valid bit. S3 drives the outputs directly from registers.
- Advance rules:
  - adv3 = !v3 | out_ready.
  - adv2 = !v2 | adv3.
  - adv1 = !v1 | adv2.
  - in_ready = adv1. This is a combinational path from `out_ready` and is permitted.
- A stage holds its data while not advancing. No beat is ever dropped or duplicated.
- Latency is 3 cycles from input handshake to `out_valid` with no stall. Throughput is 1 beat/cycle while `out_ready` = 1.
- `out_data`, `out_sat` and opcode are stable while out_valid & !out_ready.
- Reset values:
  - all valid bits 0, so `out_valid`=0 and `in_ready`=1;
  - `out_data` = 0, `out_sat` = 0, `sat_count` = 0.
- Reset mid-operation discards all in-flight beats.
- Changing `out_scale` affects only beats entering S3 after the change.

## Structure
- Package `activation_pkg` holds:
  - the 3-bit opcode localparams;
  - functions for hs(), the generic clamp and sat(DATA_WIDTH).
- Sub-module `activation_lane`: one lane's S1/S2/S3 datapath registers, no valid logic. It is instantiated LANES times.
- The top level owns the valid/ready control, the `sat_count` counter and lane packing.

## Test plan
Settings: DATA_WIDTH=16, FRAC_BITS=8, `out_scale`=256 unless stated.

- RELU, lanes {−5, 300}, RELU6 lane 2000, LEAKY lane −64 → 0, 300, 1536, −8, all 3 cycles after acceptance.
- SIGMOID on x = 0 / 1024 / −1024 → 128 / 256 / 0. TANH on x=−700 → −256. SWISH on x=256 → 192. GELU on x=−1024 → 0.
- NONE, x=10000, `out_scale`=1024 → 32767, `out_sat` lane bit = 1, `sat_count` = 1. Assert `sat_clr` on a same-cycle saturated handshake → `sat_count` = 0.
- Stream 10 beats with `out_ready` toggling pseudo-randomly → all 10 outputs in order and unchanged during stalls. `in_ready` low only when all three stages are full and `out_ready` = 0.
- Assert `rst` with 3 beats in flight → `out_valid` = 0 and `in_ready` = 1 immediately. No stale beat appears after release.
- Preset `sat_count` to all-ones via saturated beats, then one more saturated beat → it stays all-ones.
